// File: rtl/matrix_multiplier_if.sv
// Operand/result bus of the sequential matrix multiplier: operand handshake in, result handshake out.
interface matrix_multiplier_seq_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int A_ROWS           = 10,
  parameter int B_COLUMNS        = 4,
  parameter int A_COLUMNS_B_ROWS = 6,
  parameter int C_DATA_WIDTH     = (2*DATA_WIDTH)+$clog2(A_COLUMNS_B_ROWS)
) ();
  logic                                                 valid_i;
  logic                                                 ready_o;
  logic                                                 acc_i;
  logic [A_ROWS*A_COLUMNS_B_ROWS-1:0][DATA_WIDTH-1:0]    a_i;
  logic [A_COLUMNS_B_ROWS*B_COLUMNS-1:0][DATA_WIDTH-1:0] b_i;
  logic                                                 valid_o;
  logic                                                 ready_i;
  logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]         c_o;
  logic                                                 busy_o;

  modport master (
    output valid_i, acc_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, c_o, busy_o
  );

  modport slave (
    input  valid_i, acc_i, a_i, b_i, ready_i,
    output ready_o, valid_o, c_o, busy_o
  );
endinterface

// File: rtl/matrix_multiplier_seq.sv
// Iterative matrix multiplier: C = A*B (optionally + previous C), one (row, k) step per cycle
// using B_COLUMNS MAC lanes, with valid/ready handshakes on operands and result.
module matrix_multiplier_seq #(
  parameter int DATA_WIDTH       = 32,
  parameter int A_ROWS           = 10,
  parameter int B_COLUMNS        = 4,
  parameter int A_COLUMNS_B_ROWS = 6,
  parameter int SIGNED           = 0,
  parameter int C_DATA_WIDTH     = (2*DATA_WIDTH)+$clog2(A_COLUMNS_B_ROWS)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  matrix_multiplier_seq_if.slave   bus
);
  localparam int K   = A_COLUMNS_B_ROWS;
  localparam int CW  = C_DATA_WIDTH;
  localparam int NA  = A_ROWS*K;
  localparam int NB  = K*B_COLUMNS;
  localparam int NC  = A_ROWS*B_COLUMNS;
  localparam int RW  = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int AIW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CIW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [KW-1:0]                       k_q, k_d;
  logic                                accm_q, accm_d;
  logic [NA-1:0][DATA_WIDTH-1:0]       a_q, a_d;
  logic [NB-1:0][DATA_WIDTH-1:0]       b_q, b_d;
  logic [B_COLUMNS-1:0][CW-1:0]        lane_q, lane_d;
  logic [NC-1:0][CW-1:0]               c_q, c_d;
  logic [AIW-1:0]                      a_idx;
  logic                                last_k;

  function automatic logic signed [CW-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED != 0) return {{(CW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    else             return {{(CW-DATA_WIDTH){1'b0}}, x};
  endfunction

  // Product truncated to CW bits; low bits are identical for signed and unsigned operands.
  function automatic logic [CW-1:0] mac_prod(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
    logic signed [CW-1:0] pa;
    logic signed [CW-1:0] pb;
    logic signed [CW-1:0] p;
    pa = ext(a);
    pb = ext(b);
    p  = pa * pb;
    return p;
  endfunction

  assign a_idx  = AIW'(int'(row_q)*K + int'(k_q));
  assign last_k = (k_q == KW'(K-1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.valid_i) state_d = S_CALC;
      S_CALC:  if (last_k && (row_q == RW'(A_ROWS-1))) state_d = S_DONE;
      S_DONE:  if (bus.ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [BIW-1:0] b_idx;
    logic [CIW-1:0] c_idx;
    logic [CW-1:0]  sum;
    row_d  = row_q;
    k_d    = k_q;
    accm_d = accm_q;
    a_d    = a_q;
    b_d    = b_q;
    lane_d = lane_q;
    c_d    = c_q;
    b_idx  = '0;
    c_idx  = '0;
    sum    = '0;
    if (state_q == S_IDLE && bus.valid_i) begin
      a_d    = bus.a_i;
      b_d    = bus.b_i;
      accm_d = bus.acc_i;
      row_d  = '0;
      k_d    = '0;
      lane_d = '0;
    end else if (state_q == S_CALC) begin
      for (int j = 0; j < B_COLUMNS; j++) begin
        b_idx = BIW'(int'(k_q)*B_COLUMNS + j);
        c_idx = CIW'(int'(row_q)*B_COLUMNS + j);
        sum   = lane_q[j] + mac_prod(a_q[a_idx], b_q[b_idx]);
        // Row complete: commit the lane sum, folding in the held result in accumulate mode.
        if (last_k) begin
          c_d[c_idx] = sum + (accm_q ? c_q[c_idx] : '0);
          lane_d[j]  = '0;
        end else begin
          lane_d[j]  = sum;
        end
      end
      if (last_k) begin
        k_d = '0;
        if (row_q != RW'(A_ROWS-1)) row_d = row_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_q  <= '0;
      k_q    <= '0;
      accm_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      lane_q <= '0;
      c_q    <= '0;
    end else begin
      row_q  <= row_d;
      k_q    <= k_d;
      accm_q <= accm_d;
      a_q    <= a_d;
      b_q    <= b_d;
      lane_q <= lane_d;
      c_q    <= c_d;
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.busy_o  = (state_q == S_CALC);
  assign bus.valid_o = (state_q == S_DONE);
  assign bus.c_o     = c_q;
endmodule
